// File: rtl/random_delay_timer_pkg.sv
// Shared definitions for the reaction-timer delay stage: default timing parameters,
// the random-number width shared with the LFSR generator, and the FSM state type.
package random_delay_timer_pkg;

  localparam int RND_W            = 14;
  localparam int CLK_PER_MS_DEF   = 100000;
  localparam int MIN_DELAY_MS_DEF = 2000;
  localparam int RAND_BITS_DEF    = 13;
  localparam int DELAY_W_DEF      = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RND,
    ST_COUNT,
    ST_DONE
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/random_delay_timer_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 while enabled and flags the wrap cycle.
module ms_tick_gen
  import random_delay_timer_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                PRE_W = cnt_width(CLK_PER_MS);
  localparam logic [PRE_W-1:0]  LAST  = PRE_W'(CLK_PER_MS - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/random_delay_timer.sv
// Reaction-timer delay stage: requests a random number, turns it into a millisecond
// delay, counts it out and raises the stimulus; an abort before expiry cancels the run.
module random_delay_timer
  import random_delay_timer_pkg::*;
#(
  parameter int CLK_PER_MS   = CLK_PER_MS_DEF,
  parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int RAND_BITS    = RAND_BITS_DEF,
  parameter int DELAY_W      = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               clear,
  output logic               rnd_start,
  input  logic               rnd_done_tick,
  input  logic [RND_W-1:0]   rnd_num,
  output logic [DELAY_W-1:0] delay_ms,
  output logic               busy,
  output logic               stimulus,
  output logic               expired_tick
);

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] ms_q, ms_d;
  logic               expired_q, expired_d;
  logic               pre_clr, pre_en, pre_tick;
  logic [DELAY_W-1:0] new_delay;
  logic               rnd_unused;

  // Only the low RAND_BITS of the generator value feed the delay.
  assign rnd_unused = ^rnd_num;
  assign new_delay  = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(rnd_num[RAND_BITS-1:0]);

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_ms_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (pre_tick)
  );

  assign pre_en = (state_q == ST_COUNT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    delay_d   = delay_q;
    ms_d      = ms_q;
    pre_clr   = 1'b0;
    rnd_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          rnd_start = 1'b1;
          state_d   = ST_WAIT_RND;
        end
      end
      ST_WAIT_RND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rnd_done_tick) begin
          delay_d = new_delay;
          ms_d    = new_delay;
          pre_clr = 1'b1;
          state_d = (new_delay == '0) ? ST_DONE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_d = ST_IDLE;
          ms_d    = '0;
          pre_clr = 1'b1;
        end else if (pre_tick) begin
          ms_d = ms_q - 1'b1;
          if (ms_q == DELAY_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort || clear) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pulse on the first DONE cycle only, whichever state it was entered from.
  assign expired_d = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      ms_q      <= '0;
      expired_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      delay_q   <= delay_d;
      ms_q      <= ms_d;
      expired_q <= expired_d;
    end
  end

  assign delay_ms     = delay_q;
  assign busy         = (state_q == ST_REQ) || (state_q == ST_WAIT_RND) || (state_q == ST_COUNT);
  assign stimulus     = (state_q == ST_DONE);
  assign expired_tick = expired_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Scoreboard bench for random_delay_timer with a behavioural LFSR responder; a second
// instance with MIN_DELAY_MS=0 covers the zero-delay path.
module tb_random_delay_timer;

  localparam int MODEL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, abort = 1'b0, clear = 1'b0;
  logic        rnd_done_tick = 1'b0;
  logic [13:0] rnd_num = '0;
  logic        rnd_start, busy, stimulus, expired_tick;
  logic [3:0]  delay_ms;

  logic        arm_b = 1'b0, abort_b = 1'b0, clear_b = 1'b0;
  logic        rnd_done_b = 1'b0;
  logic [13:0] rnd_num_b = '0;
  logic        rnd_start_b, busy_b, stimulus_b, expired_tick_b;
  logic [3:0]  delay_ms_b;

  random_delay_timer #(
    .CLK_PER_MS(4), .MIN_DELAY_MS(3), .RAND_BITS(2), .DELAY_W(4)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .clear(clear),
    .rnd_start(rnd_start), .rnd_done_tick(rnd_done_tick), .rnd_num(rnd_num),
    .delay_ms(delay_ms), .busy(busy), .stimulus(stimulus), .expired_tick(expired_tick)
  );

  random_delay_timer #(
    .CLK_PER_MS(4), .MIN_DELAY_MS(0), .RAND_BITS(2), .DELAY_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .arm(arm_b), .abort(abort_b), .clear(clear_b),
    .rnd_start(rnd_start_b), .rnd_done_tick(rnd_done_b), .rnd_num(rnd_num_b),
    .delay_ms(delay_ms_b), .busy(busy_b), .stimulus(stimulus_b), .expired_tick(expired_tick_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_RND, EV_EXP} ev_e;
  typedef struct {
    ev_e kind;
    int  gap;
    int  dly;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          arm_cyc = 0;
  int          done_cyc = 0;
  logic [13:0] model_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per presented output event.
  initial begin : monitor
    exp_t e;
    bit   exp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_prev) check("expired_one_cycle", expired_tick, 0);
      exp_prev = expired_tick;
      if (rnd_start) begin
        if (sb.size() == 0 || sb[0].kind != EV_RND) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rnd_start: got rnd_start=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("arm_to_rnd_start", cyc - arm_cyc, e.gap);
        end
      end
      if (expired_tick) begin
        if (sb.size() == 0 || sb[0].kind != EV_EXP) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_expire: got expired_tick=1 at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("done_to_expire_cycles", cyc - done_cyc, e.gap);
          check("expire_delay_ms", delay_ms, e.dly);
          check("expire_stimulus", stimulus, 1);
        end
      end
    end
  end

  // Behavioural LFSR: answers each request MODEL_LAT cycles later, even after an abort.
  initial begin : lfsr_model
    forever begin
      @(negedge clk);
      if (rnd_start && !reset) begin
        repeat (MODEL_LAT) step();
        rnd_num       = model_val;
        rnd_done_tick = 1'b1;
        done_cyc      = cyc;
        step();
        rnd_done_tick = 1'b0;
        rnd_num       = '0;
      end
    end
  end

  task automatic arm_run(input logic [13:0] v, input bit want_exp, input int dly, input int gap);
    model_val = v;
    sb.push_back('{kind: EV_RND, gap: 1, dly: 0});
    if (want_exp) sb.push_back('{kind: EV_EXP, gap: gap, dly: dly});
    step();
    arm     = 1'b1;
    arm_cyc = cyc;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_stim(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (stimulus) break;
    end
    check(name, stimulus, 1);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_stimulus", stimulus, 0);
    check("rst_rnd_start", rnd_start, 0);
    check("rst_expired", expired_tick, 0);
    check("rst_delay_ms", delay_ms, 0);
    step();
    reset = 1'b0;

    // 1: rnd 0x0005 -> 3+1=4 ms, 16 COUNT cycles
    arm_run(14'h0005, 1'b1, 4, 4 * 4 + 1);
    check("t1_busy_after_arm", busy, 1);
    wait_stim(60, "t1_reach_done");
    step();
    check("t1_stimulus_hold", stimulus, 1);
    clear_pulse();
    check("t1_stimulus_after_clear", stimulus, 0);

    // 2: rnd 0x3FFF -> 3+3=6 ms, 24 COUNT cycles
    arm_run(14'h3FFF, 1'b1, 6, 6 * 4 + 1);
    wait_stim(60, "t2_reach_done");
    step();
    check("t2_stimulus_hold", stimulus, 1);
    clear_pulse();
    check("t2_stimulus_after_clear", stimulus, 0);
    check("t2_busy_after_clear", busy, 0);

    // 3: abort on COUNT cycle 7 of a 4 ms run, then re-arm with rnd 0 -> 3 ms
    arm_run(14'h0001, 1'b0, 0, 0);
    repeat (MODEL_LAT + 7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_busy_after_abort", busy, 0);
    check("t3_delay_held", delay_ms, 4);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= stimulus;
    end
    check("t3_no_stimulus", seen, 0);
    arm_run(14'h0000, 1'b1, 3, 3 * 4 + 1);
    wait_stim(60, "t3_rearm_reach_done");
    clear_pulse();

    // 4: abort in WAIT_RND; the late rnd_done_tick must be ignored
    arm_run(14'h0002, 1'b0, 0, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (MODEL_LAT + 2) step();
    check("t4_busy", busy, 0);
    check("t4_delay_unchanged", delay_ms, 3);
    check("t4_stimulus", stimulus, 0);

    // 5a: arm and abort together while in REQ
    step();
    arm = 1'b1;
    step();
    abort = 1'b1;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    check("t5_req_abort_busy", busy, 0);
    step();
    check("t5_req_abort_idle", busy, 0);

    // 5b: clear and arm together in DONE
    arm_run(14'h0000, 1'b1, 3, 3 * 4 + 1);
    wait_stim(60, "t5_reach_done");
    clear = 1'b1;
    arm   = 1'b1;
    step();
    clear = 1'b0;
    arm   = 1'b0;
    check("t5_done_clear_stimulus", stimulus, 0);
    check("t5_done_clear_busy", busy, 0);
    step();
    check("t5_arm_ignored", busy, 0);

    // 6: async reset mid-COUNT, between clock edges
    arm_run(14'h0001, 1'b0, 0, 0);
    repeat (MODEL_LAT + 5) step();
    check("t6_in_count", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_stimulus", stimulus, 0);
    check("t6_rst_rnd_start", rnd_start, 0);
    check("t6_rst_expired", expired_tick, 0);
    check("t6_rst_delay_ms", delay_ms, 0);
    step();
    reset = 1'b0;

    // 6b: MIN_DELAY_MS=0 with rnd 0 -> DONE one cycle after rnd_done_tick
    step();
    arm_b = 1'b1;
    step();
    arm_b = 1'b0;
    check("t6b_rnd_start", rnd_start_b, 1);
    step();
    rnd_num_b  = '0;
    rnd_done_b = 1'b1;
    step();
    rnd_done_b = 1'b0;
    check("t6b_stimulus", stimulus_b, 1);
    check("t6b_expired", expired_tick_b, 1);
    check("t6b_busy", busy_b, 0);
    check("t6b_delay_ms", delay_ms_b, 0);
    step();
    check("t6b_expired_one_cycle", expired_tick_b, 0);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
